// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb -- writeback arbiter in front of the GPR write port.
//
// Merges ALU results and buffered LSU (load) results into the single GPR
// write port. Load results are queued in a small FIFO. The ALU normally has
// priority. The FIFO head is drained first when any of these holds:
//   - the FIFO is full;
//   - the head has been bypassed STARVE_MAX times in a row;
//   - the incoming ALU destination matches a buffered load (WAW ordering).
// The selected write is registered, so the port outputs have a latency of
// one cycle after selection.
//
// Parameters:
//   DEPTH      LSU result FIFO entries (power of 2, >= 2)
//   STARVE_MAX max consecutive bypasses of a non-empty FIFO head
//
// Ports:
//   clk, reset          core clock, asynchronous active-high reset
//   alu_valid/adr/dat   ALU result in; alu_ready = accepted this cycle
//   lsu_valid/adr/dat   load result in; lsu_ready = FIFO has room
//   wr_en_0/adr_0/dat_0 registered GPR write port
//   pend_cnt            registered FIFO occupancy
//   byp_valid/adr/dat   combinational copy of the selected write, one cycle
//                       ahead of wr_en_0 (only with GPR_WB_ARB_BYPASS_EN)
//
// Optional feature macro: GPR_WB_ARB_BYPASS_EN
module gpr_wb_arb #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_adr,
  input  logic [31:0]              alu_dat,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_adr,
  input  logic [31:0]              lsu_dat,
  output logic                     wr_en_0,
  output logic [4:0]               wr_adr_0,
  output logic [31:0]              wr_dat_0,
  output logic [$clog2(DEPTH):0]   pend_cnt
`ifdef GPR_WB_ARB_BYPASS_EN
  ,
  output logic                     byp_valid,
  output logic [4:0]               byp_adr,
  output logic [31:0]              byp_dat
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  // FIFO storage (data path, no reset needed) and per-entry valid bits
  logic [4:0]       r_adr [DEPTH];
  logic [31:0]      r_dat [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;

  logic        w_full;
  logic        w_nonempty;
  logic        w_hit;
  logic        w_force;
  logic        w_push;
  logic        w_pop;
  logic        w_alu_win;
  logic        w_sel_en;
  logic [4:0]  w_sel_adr;
  logic [31:0] w_sel_dat;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nonempty = (r_count != '0);

  // WAW guard: any buffered load targeting the incoming ALU destination
  always_comb begin
    w_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_adr[i] == alu_adr)) begin
        w_hit = 1'b1;
      end
    end
  end

  assign w_force = w_full
                 | (w_nonempty & (r_starve == SW'(STARVE_MAX)))
                 | (alu_valid & w_hit);

  // force can only be true with a non-empty FIFO (hit needs a valid entry)
  assign w_pop     = w_nonempty & (w_force | ~alu_valid);
  assign w_alu_win = alu_valid & ~w_force;
  assign w_push    = lsu_valid & lsu_ready;

  assign w_sel_en  = w_pop | w_alu_win;
  assign w_sel_adr = w_pop ? r_adr[r_rd_ptr] : alu_adr;
  assign w_sel_dat = w_pop ? r_dat[r_rd_ptr] : alu_dat;

  assign alu_ready = ~w_force;
  assign lsu_ready = ~w_full;
  assign pend_cnt  = r_count;

`ifdef GPR_WB_ARB_BYPASS_EN
  assign byp_valid = w_sel_en & ~reset;
  assign byp_adr   = w_sel_adr;
  assign byp_dat   = w_sel_dat;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_adr[r_wr_ptr] <= lsu_adr;
      r_dat[r_wr_ptr] <= lsu_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      wr_en_0  <= 1'b0;
      wr_adr_0 <= '0;
      wr_dat_0 <= '0;
    end else begin
      // Push and pop never hit the same slot: that would need a full FIFO
      // being pushed or an empty FIFO being popped.
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (!w_nonempty || w_pop) begin
        r_starve <= '0;
      end else if (w_alu_win && (r_starve != SW'(STARVE_MAX))) begin
        r_starve <= r_starve + 1'b1;
      end

      wr_en_0 <= w_sel_en;
      if (w_sel_en) begin
        wr_adr_0 <= w_sel_adr;
        wr_dat_0 <= w_sel_dat;
      end
    end
  end

endmodule
